alu_program_sequencer: RTL and testbench

Micro-program sequencer that drives the tiny 4-bit ALU (`tt_um_tiny_4bit_alu`).
- Holds a 16-entry × 12-bit program memory loaded over a simple write port.
- On `start`, steps through the program, issuing each ALU instruction and holding the operands stable for the ALU's two-cycle registered latency.
- Captures result and flags, and supports unconditional jumps and branch-on-zero.
- Sits between the host and the ALU, replacing direct host control of `ui_in`/`uio_in`.

---
 rtl/alu_seq_pkg.sv | 47 ++++
 rtl/alu_program_sequencer_if.sv | 35 +++
 rtl/alu_seq_progmem.sv | 44 ++++
 rtl/alu_program_sequencer.sv | 168 ++++++++++++++++
 tb/tb_alu_program_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module : alu_seq_pkg
// Brief  : Shared opcodes, state encoding and field widths for the ALU
//          program sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

    localparam int ADDR_W  = 4;
    localparam int FIELD_W = 4;
    localparam int INSTR_W = 12;
    localparam int DEPTH   = 16;
    localparam int CNT_W   = 8;

    localparam logic [FIELD_W-1:0] OP_ADD       = 4'h0;
    localparam logic [FIELD_W-1:0] OP_SUB       = 4'h1;
    localparam logic [FIELD_W-1:0] OP_REG_WRITE = 4'h8;
    localparam logic [FIELD_W-1:0] OP_ALU_LAST  = 4'hB;
    localparam logic [FIELD_W-1:0] OP_BRZ       = 4'hC;
    localparam logic [FIELD_W-1:0] OP_JMP       = 4'hD;
    localparam logic [FIELD_W-1:0] OP_NOP       = 4'hE;
    localparam logic [FIELD_W-1:0] OP_HALT      = 4'hF;

    localparam logic [INSTR_W-1:0] INSTR_HALT = 12'hF00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [FIELD_W-1:0] op;
        logic [FIELD_W-1:0] b;
        logic [FIELD_W-1:0] a;
    } instr_t;

    function automatic logic is_alu_op(input logic [FIELD_W-1:0] op);
        return (op <= OP_ALU_LAST);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_program_sequencer_if.sv
// ============================================================================
// Module : alu_program_sequencer_if
// Brief  : Host-side program/control bus and ALU-side drive/status bundle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_program_sequencer_if;
    logic        ena;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [11:0] load_data;
    logic        start;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [3:0]  pc;
    logic [7:0]  alu_ui;
    logic [7:0]  alu_uio;
    logic [7:0]  alu_status;
    logic [3:0]  last_result;
    logic [3:0]  last_flags;

    modport slave (
        input  ena, load_en, load_addr, load_data, start, alu_status,
        output busy, done, aborted, pc, alu_ui, alu_uio, last_result, last_flags
    );

    modport master (
        output ena, load_en, load_addr, load_data, start, alu_status,
        input  busy, done, aborted, pc, alu_ui, alu_uio, last_result, last_flags
    );
endinterface

`default_nettype wire

// File: rtl/alu_seq_progmem.sv
// ============================================================================
// Module : alu_seq_progmem
// Brief  : 16 x 12 program store, resets to HALT, one write / one comb read.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_progmem
    import alu_seq_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               wr_en,
    input  wire logic [ADDR_W-1:0]  wr_addr,
    input  wire logic [INSTR_W-1:0] wr_data,
    input  wire logic [ADDR_W-1:0]  rd_addr,
    output logic      [INSTR_W-1:0] rd_data
);

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [INSTR_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= INSTR_HALT;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

`default_nettype wire

// File: rtl/alu_program_sequencer.sv
// ============================================================================
// Module : alu_program_sequencer
// Brief  : Steps a stored micro-program through the tiny 4-bit ALU.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_program_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ALU_LATENCY = 2,
    parameter int MAX_STEPS   = 255
) (
    input wire logic                 clk,
    input wire logic                 rst_n,
    alu_program_sequencer_if.slave   bus
);

    localparam logic [CNT_W-1:0]  STEP_LIMIT = CNT_W'(MAX_STEPS);
    localparam logic [CNT_W-1:0]  LAT_LOAD   = CNT_W'(ALU_LATENCY);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [ADDR_W-1:0] PC_ONE     = ADDR_W'(1);

    seq_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]   step_q, step_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic               aborted_q, aborted_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [3:0]         result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic [7:0]         alu_ui_q, alu_ui_d;
    logic [7:0]         alu_uio_q, alu_uio_d;
    logic [FIELD_W-1:0] ir_op_q, ir_op_d;
    logic [FIELD_W-1:0] ir_a_q, ir_a_d;

    logic               wr_en;
    logic [INSTR_W-1:0] rd_data;
    instr_t             nxt_instr;
    logic               drive_alu;

    assign wr_en = bus.load_en & bus.ena & (state_q == ST_IDLE);

    alu_seq_progmem u_progmem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (bus.load_addr),
        .wr_data (bus.load_data),
        .rd_addr (pc_d),
        .rd_data (rd_data)
    );

    // Fetch targets next cycle's pc; a same-cycle write to that slot is
    // forwarded so a load+start pair executes the freshly written word.
    assign nxt_instr = (wr_en && (bus.load_addr == pc_d)) ? instr_t'(bus.load_data)
                                                           : instr_t'(rd_data);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        step_d    = step_q;
        wait_d    = wait_q;
        aborted_d = aborted_q;
        result_d  = result_q;
        flags_d   = flags_q;
        if (bus.ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_d   = ST_ISSUE;
                        pc_d      = '0;
                        step_d    = '0;
                        aborted_d = 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (step_q == STEP_LIMIT) begin
                        state_d   = ST_DONE;
                        aborted_d = 1'b1;
                    end else begin
                        step_d = step_q + CNT_ONE;
                        if (is_alu_op(ir_op_q)) begin
                            state_d = ST_WAIT;
                            wait_d  = LAT_LOAD;
                        end else begin
                            case (ir_op_q)
                                OP_BRZ:  pc_d = flags_q[3] ? ir_a_q : pc_q + PC_ONE;
                                OP_JMP:  pc_d = ir_a_q;
                                OP_NOP:  pc_d = pc_q + PC_ONE;
                                default: state_d = ST_DONE;
                            endcase
                        end
                    end
                end
                ST_WAIT: begin
                    wait_d = wait_q - CNT_ONE;
                    if (wait_d == '0) begin
                        result_d = bus.alu_status[3:0];
                        flags_d  = bus.alu_status[7:4];
                        pc_d     = pc_q + PC_ONE;
                        state_d  = ST_ISSUE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q == ST_WAIT) begin
            // ALU output reads 0 while disabled, so restart the latency window.
            wait_d = LAT_LOAD;
        end
    end

    always_comb begin
        done_d    = (state_d == ST_DONE);
        busy_d    = (state_d != ST_IDLE);
        ir_op_d   = nxt_instr.op;
        ir_a_d    = nxt_instr.a;
        drive_alu = (state_d == ST_WAIT) ||
                    ((state_d == ST_ISSUE) && is_alu_op(nxt_instr.op) && (step_d != STEP_LIMIT));
        alu_ui_d  = drive_alu ? {nxt_instr.b, nxt_instr.a} : 8'h00;
        alu_uio_d = drive_alu ? {4'h0, nxt_instr.op}       : {4'h0, OP_HALT};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            step_q    <= '0;
            wait_q    <= '0;
            aborted_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            result_q  <= '0;
            flags_q   <= '0;
            alu_ui_q  <= 8'h00;
            alu_uio_q <= 8'h0F;
            ir_op_q   <= OP_HALT;
            ir_a_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            step_q    <= step_d;
            wait_q    <= wait_d;
            aborted_q <= aborted_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            alu_ui_q  <= alu_ui_d;
            alu_uio_q <= alu_uio_d;
            ir_op_q   <= ir_op_d;
            ir_a_q    <= ir_a_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.aborted     = aborted_q;
    assign bus.pc          = pc_q;
    assign bus.alu_ui      = alu_ui_q;
    assign bus.alu_uio     = alu_uio_q;
    assign bus.last_result = result_q;
    assign bus.last_flags  = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_program_sequencer.sv
// ============================================================================
// Module : tb_alu_program_sequencer
// Brief  : Scoreboard bench for the sequencer with a two-stage ALU model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_program_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_program_sequencer_if bus ();

    alu_program_sequencer #(.ALU_LATENCY(2), .MAX_STEPS(255)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural ALU: two registered stages, output forced to 0 when disabled.
    logic [7:0] s1, s2;

    function automatic logic [7:0] alu_fn(input logic [7:0] ui, input logic [7:0] uio);
        logic [3:0] a, b, r;
        logic       c, v;
        logic [4:0] t;
        a = ui[3:0]; b = ui[7:4]; r = 4'h0; c = 1'b0; v = 1'b0; t = 5'h0;
        case (uio[3:0])
            4'h0: begin t = {1'b0, a} + {1'b0, b}; r = t[3:0]; c = t[4];
                        v = (a[3] == b[3]) && (r[3] != a[3]); end
            4'h1: begin t = {1'b0, a} - {1'b0, b}; r = t[3:0]; c = t[4];
                        v = (a[3] != b[3]) && (r[3] != a[3]); end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            default: r = 4'h0;
        endcase
        return {(r == 4'h0), r[3], v, c, r};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 8'h00; s2 <= 8'h00;
        end else if (bus.ena) begin
            s1 <= alu_fn(bus.alu_ui, bus.alu_uio);
            s2 <= s1;
        end
    end
    assign bus.alu_status = bus.ena ? s2 : 8'h00;

    typedef struct {
        logic [3:0] res;
        logic [3:0] flags;
        logic       ab;
        int         dcyc;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] pc_trace[$];
    int         checks   = 0;
    int         failures = 0;

    task automatic do_reset();
        rst_n = 1'b0;
        bus.ena = 1'b1; bus.load_en = 1'b0; bus.load_addr = 4'h0;
        bus.load_data = 12'h000; bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic load(input logic [3:0] a, input logic [11:0] d);
        bus.load_en = 1'b1; bus.load_addr = a; bus.load_data = d;
        @(negedge clk);
        bus.load_en = 1'b0;
    endtask

    // Pulses start (optionally with a simultaneous write), samples each cycle.
    task automatic run(input int budget, input logic wr, input logic [3:0] wa,
                       input logic [11:0] wd, output int dcyc);
        bus.start = 1'b1; bus.load_en = wr; bus.load_addr = wa; bus.load_data = wd;
        @(negedge clk);
        bus.start = 1'b0; bus.load_en = 1'b0;
        dcyc = -1;
        pc_trace.delete();
        for (int c = 1; c <= budget; c++) begin
            if (bus.busy && (pc_trace.size() == 0 || pc_trace[$] != bus.pc))
                pc_trace.push_back(bus.pc);
            if (bus.done) begin dcyc = c; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.busy, bus.done, bus.aborted, bus.pc, bus.last_result, bus.last_flags} !== 15'h0) begin
            failures++;
            $display("FAIL reset_ctrl: got busy=%b done=%b ab=%b pc=%h res=%h fl=%h required all 0",
                     bus.busy, bus.done, bus.aborted, bus.pc, bus.last_result, bus.last_flags);
        end
        checks++;
        if ({bus.alu_uio, bus.alu_ui} !== 16'h0F00) begin
            failures++;
            $display("FAIL reset_alu: got uio=%h ui=%h required 0f/00", bus.alu_uio, bus.alu_ui);
        end
    endtask

    task automatic test_add();
        exp_t e;
        int   d = -1;
        do_reset();
        load(4'h0, 12'h043);
        sb.push_back('{4'd7, 4'b0000, 1'b0, 5});
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c <= 3) begin
                checks++;
                if ({bus.alu_uio, bus.alu_ui} !== 16'h0043) begin
                    failures++;
                    $display("FAIL add_drive c%0d: got uio=%h ui=%h required 00/43", c, bus.alu_uio, bus.alu_ui);
                end
            end
            if (bus.done && d < 0) d = c;
            if (c == 6) begin
                checks++;
                if (bus.busy !== 1'b0) begin
                    failures++;
                    $display("FAIL add_busy_drop: got %b required 0", bus.busy);
                end
            end
            @(negedge clk);
        end
        e = sb.pop_front();
        checks++;
        if (d !== e.dcyc || bus.last_result !== e.res || bus.last_flags !== e.flags || bus.aborted !== e.ab) begin
            failures++;
            $display("FAIL add_result: got cyc=%0d res=%h fl=%b ab=%b required cyc=%0d res=%h fl=%b ab=%b",
                     d, bus.last_result, bus.last_flags, bus.aborted, e.dcyc, e.res, e.flags, e.ab);
        end
    endtask

    task automatic test_sub();
        exp_t e;
        int   d;
        do_reset();
        load(4'h0, 12'h152);
        sb.push_back('{4'hD, 4'b0101, 1'b0, 5});
        run(20, 1'b0, 4'h0, 12'h0, d);
        e = sb.pop_front();
        checks++;
        if (d !== e.dcyc || bus.last_result !== e.res || bus.last_flags !== e.flags) begin
            failures++;
            $display("FAIL sub_result: got cyc=%0d res=%h fl=%b required cyc=%0d res=%h fl=%b",
                     d, bus.last_result, bus.last_flags, e.dcyc, e.res, e.flags);
        end
    endtask

    task automatic test_branch();
        exp_t       e;
        int         d;
        logic [3:0] exp_pc[5] = '{4'h0, 4'h1, 4'h2, 4'h5, 4'h6};
        logic       ok;
        do_reset();
        load(4'h0, 12'h811);
        load(4'h1, 12'h111);
        load(4'h2, 12'hC05);
        load(4'h5, 12'h3A5);
        sb.push_back('{4'hF, 4'b0100, 1'b0, 12});
        run(40, 1'b0, 4'h0, 12'h0, d);
        ok = (pc_trace.size() == 5);
        for (int i = 0; i < 5 && ok; i++) ok = (pc_trace[i] == exp_pc[i]);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL branch_pc: got %p required 0,1,2,5,6", pc_trace);
        end
        e = sb.pop_front();
        checks++;
        if (d !== e.dcyc || bus.last_result !== e.res || bus.last_flags !== e.flags) begin
            failures++;
            $display("FAIL branch_result: got cyc=%0d res=%h fl=%b required cyc=%0d res=%h fl=%b",
                     d, bus.last_result, bus.last_flags, e.dcyc, e.res, e.flags);
        end
    endtask

    task automatic test_abort();
        exp_t e;
        int   d;
        do_reset();
        load(4'h0, 12'hD00);
        sb.push_back('{4'h0, 4'h0, 1'b1, 257});
        run(300, 1'b0, 4'h0, 12'h0, d);
        e = sb.pop_front();
        checks++;
        if (d !== e.dcyc || bus.aborted !== e.ab) begin
            failures++;
            $display("FAIL abort_done: got cyc=%0d ab=%b required cyc=%0d ab=%b", d, bus.aborted, e.dcyc, e.ab);
        end
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.aborted !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_clear: got ab=%b busy=%b required ab=0 busy=1", bus.aborted, bus.busy);
        end
    endtask

    task automatic test_ena_wait();
        exp_t e;
        int   d = -1;
        do_reset();
        load(4'h0, 12'h043);
        sb.push_back('{4'd7, 4'b0000, 1'b0, 9});
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (bus.done && d < 0) d = c;
            if (c == 3) bus.ena = 1'b0;
            if (c == 6) bus.ena = 1'b1;
            @(negedge clk);
        end
        e = sb.pop_front();
        checks++;
        if (d !== e.dcyc || bus.last_result !== e.res) begin
            failures++;
            $display("FAIL ena_wait: got cyc=%0d res=%h required cyc=%0d res=%h", d, bus.last_result, e.dcyc, e.res);
        end
    endtask

    task automatic test_load_busy();
        exp_t e;
        int   d;
        do_reset();
        load(4'h0, 12'h043);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        load(4'h1, 12'hD00);
        repeat (6) @(negedge clk);
        sb.push_back('{4'd7, 4'b0000, 1'b0, 5});
        run(300, 1'b0, 4'h0, 12'h0, d);
        e = sb.pop_front();
        checks++;
        if (d !== e.dcyc || bus.aborted !== e.ab) begin
            failures++;
            $display("FAIL load_busy: got cyc=%0d ab=%b required cyc=%0d ab=%b", d, bus.aborted, e.dcyc, e.ab);
        end
        @(negedge clk);
        sb.push_back('{4'hD, 4'b0101, 1'b0, 5});
        run(20, 1'b1, 4'h0, 12'h152, d);
        e = sb.pop_front();
        checks++;
        if (d !== e.dcyc || bus.last_result !== e.res || bus.last_flags !== e.flags) begin
            failures++;
            $display("FAIL load_start_same: got cyc=%0d res=%h fl=%b required cyc=%0d res=%h fl=%b",
                     d, bus.last_result, bus.last_flags, e.dcyc, e.res, e.flags);
        end
    endtask

    task automatic test_reset_midrun();
        int d;
        do_reset();
        load(4'h0, 12'h043);
        run(20, 1'b0, 4'h0, 12'h0, d);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.aborted, bus.pc, bus.last_result, bus.last_flags,
             bus.alu_uio, bus.alu_ui} !== {15'h0, 16'h0F00}) begin
            failures++;
            $display("FAIL reset_midrun: got busy=%b pc=%h res=%h fl=%h uio=%h ui=%h required 0/0/0/0/0f/00",
                     bus.busy, bus.pc, bus.last_result, bus.last_flags, bus.alu_uio, bus.alu_ui);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sb.push_back('{4'h0, 4'h0, 1'b0, 2});
        run(20, 1'b0, 4'h0, 12'h0, d);
        checks++;
        if (d !== sb[0].dcyc || bus.last_result !== sb[0].res) begin
            failures++;
            $display("FAIL reset_mem_halt: got cyc=%0d res=%h required cyc=%0d res=%h",
                     d, bus.last_result, sb[0].dcyc, sb[0].res);
        end
        void'(sb.pop_front());
    endtask

    initial begin
        rst_n = 1'b0;
        bus.ena = 1'b1; bus.load_en = 1'b0; bus.load_addr = 4'h0;
        bus.load_data = 12'h000; bus.start = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_branch();
        test_abort();
        test_ena_wait();
        test_load_busy();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
